// File: rtl/vc_merge_if.sv
// rtl/vc_merge_if.sv - channel-FIFO / downstream-FIFO signal bundle for vc_merge
// word_cnt exists only when VC_MERGE_COUNT_EN is defined.
interface vc_merge_if #(
    parameter int LINE_SIZE = 12
);
    logic [3:0]             empty_f;
    logic [4*LINE_SIZE-1:0] data_in;
    logic                   almost_full_out;
    logic [3:0]             pop;
    logic                   push_out;
    logic [LINE_SIZE-1:0]   data_out;
    logic [3:0]             state;
`ifdef VC_MERGE_COUNT_EN
    logic [31:0]            word_cnt;
`endif

    // master: the FIFO environment around the merge block
    modport master (
        output empty_f, data_in, almost_full_out,
`ifdef VC_MERGE_COUNT_EN
        input  word_cnt,
`endif
        input  pop, push_out, data_out, state
    );

    // slave: the merge block itself
    modport slave (
        input  empty_f, data_in, almost_full_out,
`ifdef VC_MERGE_COUNT_EN
        output word_cnt,
`endif
        output pop, push_out, data_out, state
    );
endinterface

// File: rtl/vc_merge.sv
// rtl/vc_merge.sv - round-robin merge of four virtual-channel FIFOs into one downstream FIFO
// Optional per-channel push counters are built with VC_MERGE_COUNT_EN.
module vc_merge #(
    parameter int LINE_SIZE = 12
) (
    input  logic      clk,
    input  logic      reset_L,
    vc_merge_if.slave bus
);
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t               r_state;
    logic [1:0]           r_last;
    logic [1:0]           r_sel;
    logic                 r_push;
    logic [LINE_SIZE-1:0] r_hold;

    logic [1:0]           w_cand;
    logic [1:0]           w_grant_idx;
    logic                 w_grant_vld;
    logic [3:0]           w_pop;
    logic [LINE_SIZE-1:0] w_word;
    logic                 w_all_empty;

    assign w_all_empty = &bus.empty_f;

    // Search starts one past the last grant; the fourth candidate wraps back to it.
    always_comb begin
        w_cand      = r_last;
        w_grant_idx = r_last;
        w_grant_vld = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_grant_vld && !bus.empty_f[w_cand]) begin
                w_grant_idx = w_cand;
                w_grant_vld = 1'b1;
            end
        end
    end

    // pop looks at this cycle's flags so a channel drained by the previous pop is never re-read.
    assign w_pop = (r_state == ST_ACTIVE && !bus.almost_full_out && w_grant_vld)
                   ? (4'b0001 << w_grant_idx) : 4'b0000;

    // Channel read data arrives the cycle after pop, alongside the registered push strobe.
    assign w_word = bus.data_in[int'(r_sel)*LINE_SIZE +: LINE_SIZE];

    assign bus.pop      = w_pop;
    assign bus.push_out = r_push;
    assign bus.data_out = r_push ? w_word : r_hold;
    assign bus.state    = r_state;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_RESET;
            r_last  <= 2'd3;
            r_sel   <= 2'd0;
            r_push  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_push <= |w_pop;
            if (|w_pop) begin
                r_sel  <= w_grant_idx;
                r_last <= w_grant_idx;
            end
            if (r_push) begin
                r_hold <= w_word;
            end
            // Leaving ACTIVE never cancels r_push, so an in-flight word still lands.
            case (r_state)
                ST_RESET:  r_state <= ST_INIT;
                ST_INIT:   r_state <= ST_IDLE;
                ST_IDLE:   if (!w_all_empty && !bus.almost_full_out) r_state <= ST_ACTIVE;
                ST_ACTIVE: if (w_all_empty || bus.almost_full_out)   r_state <= ST_IDLE;
                default:   r_state <= ST_RESET;
            endcase
        end
    end

`ifdef VC_MERGE_COUNT_EN
    logic [7:0] r_cnt [4];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else if (r_push) begin
            r_cnt[r_sel] <= r_cnt[r_sel] + 8'd1;
        end
    end

    assign bus.word_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_vc_merge.sv
// tb/tb_vc_merge.sv - self-checking bench for vc_merge with FIFO models and a push scoreboard
// Covers the word counters when VC_MERGE_COUNT_EN is defined.
module tb_vc_merge;
    localparam int LS = 12;

    logic clk;
    logic reset_L;
    int   n_checks;
    int   n_pass;

    logic [LS-1:0] q    [4][$];
    logic [LS-1:0] pend [4][$];
    logic [LS-1:0] exp_q[$];

    vc_merge_if #(.LINE_SIZE(LS)) bus();

    vc_merge #(.LINE_SIZE(LS)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel FIFO models: read data registered on pop, loads staged through pend.
    always @(posedge clk) begin
        logic [LS-1:0] w;
        logic [3:0]    nxt_empty;
        nxt_empty = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (bus.pop[i] === 1'b1 && q[i].size() > 0) begin
                w = q[i].pop_front();
                bus.data_in[i*LS +: LS] <= w;
            end
            while (pend[i].size() > 0) begin
                q[i].push_back(pend[i].pop_front());
            end
            nxt_empty[i] = (q[i].size() == 0);
        end
        bus.empty_f <= nxt_empty;
    end

    // Push scoreboard and pop legality monitor.
    always @(negedge clk) begin
        logic [LS-1:0] w;
        if (bus.push_out === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL push_unexpected: push_out=1 data_out=%h, required no push", bus.data_out);
            end else begin
                w = exp_q.pop_front();
                if (bus.data_out !== w) $display("FAIL push_data: data_out=%h, required %h", bus.data_out, w);
                else n_pass++;
            end
        end
        if (bus.pop !== 4'b0000) begin
            n_checks++;
            if ($countones(bus.pop) != 1 || bus.state !== 4'b1000 || bus.almost_full_out !== 1'b0 ||
                (bus.pop[0] && q[0].size() == 0) || (bus.pop[1] && q[1].size() == 0) ||
                (bus.pop[2] && q[2].size() == 0) || (bus.pop[3] && q[3].size() == 0))
                $display("FAIL pop_legal: pop=%b state=%b af=%b, required one-hot pop of a non-empty channel in ACTIVE with af=0",
                         bus.pop, bus.state, bus.almost_full_out);
            else n_pass++;
        end
    end

    task automatic test_reset();
        reset_L = 1'b0;
        bus.almost_full_out = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.state !== 4'b0001 || bus.pop !== 4'b0 || bus.push_out !== 1'b0 || bus.data_out !== '0)
            $display("FAIL reset_out: state=%b pop=%b push=%b data=%h, required 0001 0000 0 000",
                     bus.state, bus.pop, bus.push_out, bus.data_out);
        else n_pass++;
        reset_L = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'b0010) $display("FAIL reset_init: state=%b, required 0010", bus.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'b0100 || bus.pop !== 4'b0 || bus.push_out !== 1'b0 || bus.data_out !== '0)
            $display("FAIL reset_idle: state=%b pop=%b push=%b data=%h, required 0100 0000 0 000",
                     bus.state, bus.pop, bus.push_out, bus.data_out);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int t;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                pend[c].push_back(LS'(12'h100 + c*16 + k));
                exp_q.push_back(LS'(12'h100 + c*16 + k));
            end
        end
        t = 0;
        while (bus.pop === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (bus.pop !== (4'b0001 << (i % 4)))
                $display("FAIL rr_pop_%0d: pop=%b, required %b", i, bus.pop, 4'b0001 << (i % 4));
            else n_pass++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.state !== 4'b0100 || exp_q.size() != 0)
            $display("FAIL rr_drain: state=%b pending=%0d, required 0100 and 0", bus.state, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_single_channel();
        int t;
        pend[2].push_back(12'hDE4);
        exp_q.push_back(12'hDE4);
        t = 0;
        while (bus.pop === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.pop !== 4'b0100 || bus.state !== 4'b1000)
            $display("FAIL single_pop: pop=%b state=%b, required 0100 1000", bus.pop, bus.state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.push_out !== 1'b1 || bus.data_out !== 12'hDE4 || bus.pop !== 4'b0)
            $display("FAIL single_push: push=%b data=%h pop=%b, required 1 de4 0000",
                     bus.push_out, bus.data_out, bus.pop);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'b0100 || bus.push_out !== 1'b0 || bus.data_out !== 12'hDE4)
            $display("FAIL single_hold: state=%b push=%b data=%h, required 0100 0 de4",
                     bus.state, bus.push_out, bus.data_out);
        else n_pass++;
    endtask

    task automatic test_almost_full();
        int t;
        int bad;
        pend[1].push_back(12'h3A1);
        pend[2].push_back(12'h3B2);
        exp_q.push_back(12'h3A1);
        exp_q.push_back(12'h3B2);
        t = 0;
        while (bus.pop === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.pop !== 4'b0010) $display("FAIL af_first_pop: pop=%b, required 0010", bus.pop);
        else n_pass++;
        @(posedge clk);
        #1 bus.almost_full_out = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.push_out !== 1'b1 || bus.data_out !== 12'h3A1 || bus.pop !== 4'b0)
            $display("FAIL af_inflight: push=%b data=%h pop=%b, required 1 3a1 0000",
                     bus.push_out, bus.data_out, bus.pop);
        else n_pass++;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.pop !== 4'b0 || bus.push_out !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || bus.state !== 4'b0100)
            $display("FAIL af_stall: bad_cycles=%0d state=%b, required 0 and 0100", bad, bus.state);
        else n_pass++;
        bus.almost_full_out = 1'b0;
        t = 0;
        while (bus.pop === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.pop !== 4'b0100) $display("FAIL af_resume: pop=%b, required 0100", bus.pop);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL af_drain: pending=%0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int t;
        pend[0].push_back(12'h0C5);
        t = 0;
        while (bus.pop === 4'b0000 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.pop !== 4'b0001) $display("FAIL rst_pop: pop=%b, required 0001", bus.pop);
        else n_pass++;
        @(posedge clk);
        #1 reset_L = 1'b0;
        #1;
        n_checks++;
        if (bus.state !== 4'b0001 || bus.push_out !== 1'b0 || bus.pop !== 4'b0 || bus.data_out !== '0)
            $display("FAIL rst_async: state=%b push=%b pop=%b data=%h, required 0001 0 0000 000",
                     bus.state, bus.push_out, bus.pop, bus.data_out);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.state !== 4'b0100 || bus.push_out !== 1'b0 || exp_q.size() != 0)
            $display("FAIL rst_recover: state=%b push=%b pending=%0d, required 0100 0 0",
                     bus.state, bus.push_out, exp_q.size());
        else n_pass++;
    endtask

`ifdef VC_MERGE_COUNT_EN
    task automatic test_word_count();
        int t;
        for (int i = 0; i < 300; i++) begin
            pend[3].push_back(LS'(i));
            exp_q.push_back(LS'(i));
        end
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL cnt_drain: pending=%0d, required 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (bus.word_cnt !== {8'd44, 24'd0})
            $display("FAIL cnt_value: word_cnt=%h, required %h", bus.word_cnt, {8'd44, 24'd0});
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_round_robin();
        test_single_channel();
        test_almost_full();
        test_reset_midflight();
`ifdef VC_MERGE_COUNT_EN
        test_word_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vc_merge.md
VC_MERGE -- requirements
Module: vc_merge

Interface
REQ-001 The block SHALL have parameter LINE_SIZE, default 12, giving the word width in bits (header/destination bits are opaque to this block).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_L, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port empty_f, input, 4 bits: per-channel empty flag of the four virtual-channel FIFOs.
REQ-005 The block SHALL have port data_in, input, 4*LINE_SIZE bits: channel i read data on bits [i*LINE_SIZE +: LINE_SIZE], valid the cycle after pop[i].
REQ-006 The block SHALL have port almost_full_out, input, 1 bit: almost-full flag of the single downstream FIFO.
REQ-007 The block SHALL have port pop, output, 4 bits: one-hot read strobe to the channel FIFOs.
REQ-008 The block SHALL have port push_out, output, 1 bit: write strobe to the downstream FIFO.
REQ-009 The block SHALL have port data_out, output, LINE_SIZE bits: word written downstream, valid when push_out=1.
REQ-010 The block SHALL have port state, output, 4 bits: one-hot FSM state.

Function
REQ-011 The FSM SHALL use one-hot states RESET=4'b0001, INIT=4'b0010, IDLE=4'b0100, ACTIVE=4'b1000.
REQ-012 RESET SHALL go to INIT on the first clock after reset_L deasserts; INIT SHALL go to IDLE on the next clock.
REQ-013 IDLE SHALL go to ACTIVE when any empty_f bit is 0 and almost_full_out=0; ACTIVE SHALL return to IDLE when all empty_f bits are 1 or almost_full_out=1, after draining any in-flight word.
REQ-014 pop SHALL only be asserted in ACTIVE, with at most one bit set, only for a channel whose empty_f bit is 0, and only when almost_full_out=0.
REQ-015 Arbitration SHALL be round-robin: search starts at channel (last_granted+1) mod 4 and grants the first non-empty channel; last_granted resets to 3 so channel 0 wins first.
REQ-016 When pop[i]=1 in cycle N, the block SHALL assert push_out=1 and drive data_out with channel i's data_in slice in cycle N+1 (latency 1 cycle, registered outputs).
REQ-017 Throughput SHALL be one word per cycle: pops on consecutive cycles, across same or different channels, are permitted.
REQ-018 An in-flight word (popped in N while almost_full_out rises in N+1) SHALL still be pushed; the downstream almost-full threshold absorbs one word.
REQ-019 Words SHALL never be dropped, duplicated or reordered within a channel.
REQ-020 When push_out=0, data_out SHALL hold its last value.

Reset
REQ-021 With reset_L=0, outputs SHALL be pop=0, push_out=0, data_out=0, state=RESET, and last_granted=3, independent of clk.
REQ-022 Reset asserted mid-transfer SHALL discard any in-flight word with no push in the following cycle.

Configuration
REQ-023 With macro VC_MERGE_COUNT_EN defined, the block SHALL add output word_cnt (4x8 bits, channel i on [i*8 +: 8]) counting pushes per channel, wrapping 255->0, reset to 0; without it, word_cnt and its counters SHALL not exist and all other behaviour is identical.

Verification
REQ-024 Reset then release: state 0001 -> 0010 -> 0100 on successive clocks; pop=0, push_out=0, data_out=0.
REQ-025 Only ch2 holds 12'hDE4: pop=4'b0100 one cycle, next cycle push_out=1, data_out=12'hDE4, then IDLE.
REQ-026 All four channels hold 2 words each, almost_full_out=0: pop order 0,1,2,3,0,1,2,3 on 8 consecutive cycles, 8 pushes in matching order.
REQ-027 almost_full_out rises the cycle after pop[1]: ch1 word still pushed, then pop=0 until almost_full_out falls, resuming at ch2.
REQ-028 reset_L pulsed low the cycle after pop[0]: no push occurs, state=0001 immediately.
REQ-029 With VC_MERGE_COUNT_EN: 300 words through ch3 -> word_cnt[31:24]=44, other counts 0.
